// File: rtl/mvm_relay_pkg.sv
// Shared types and default sizes for the mvm_vec_relay link stage.
package mvm_relay_pkg;

  localparam int VEC_LEN_DEF   = 12;
  localparam int IN_WIDTH_DEF  = 32;
  localparam int OUT_WIDTH_DEF = 16;

  typedef logic signed [IN_WIDTH_DEF-1:0]  in_word_t;
  typedef logic signed [OUT_WIDTH_DEF-1:0] out_word_t;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_CAPT = 1'b1
  } cap_state_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_LOAD = 2'd1,
    D_SEND = 2'd2
  } drn_state_t;

  // Ping-pong bank pointer advance.
  function automatic logic next_bank(input logic bank);
    return ~bank;
  endfunction

endpackage

// File: rtl/mvm_relay_sat.sv
// Shift, clamp and narrow one upstream result word.
// With MVM_RELAY_RELU_EN defined, negative results are forced to zero after clamping.
module mvm_relay_sat
  import mvm_relay_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int SHIFT     = 0
) (
  input  logic signed [IN_WIDTH-1:0]  word,
  output logic signed [OUT_WIDTH-1:0] narrowed,
  output logic                        saturated
);

  localparam logic signed [IN_WIDTH-1:0] MAX_WIDE =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] MIN_WIDE =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] MAX_NARROW = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] MIN_NARROW = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic signed [IN_WIDTH-1:0]  shifted;
  logic signed [OUT_WIDTH-1:0] clamped;

  // Arithmetic shift then clamp into the signed output range.
  always_comb begin
    shifted   = word >>> SHIFT;
    clamped   = shifted[OUT_WIDTH-1:0];
    saturated = 1'b0;
    if (shifted > MAX_WIDE) begin
      clamped   = MAX_NARROW;
      saturated = 1'b1;
    end else if (shifted < MIN_WIDE) begin
      clamped   = MIN_NARROW;
      saturated = 1'b1;
    end else begin
      clamped   = shifted[OUT_WIDTH-1:0];
      saturated = 1'b0;
    end
  end

`ifdef MVM_RELAY_RELU_EN
  // ReLU acts on the clamped value; the saturation flag is left untouched.
  always_comb begin
    if (clamped[OUT_WIDTH-1]) begin
      narrowed = {OUT_WIDTH{1'b0}};
    end else begin
      narrowed = clamped;
    end
  end
`else
  assign narrowed = clamped;
`endif

endmodule

// File: rtl/mvm_vec_relay.sv
// Captures an mvm result burst into ping-pong banks and replays it as a loadVector burst.
// Optional ReLU on the capture path is enabled by defining MVM_RELAY_RELU_EN.
module mvm_vec_relay
  import mvm_relay_pkg::*;
#(
  parameter int VEC_LEN   = VEC_LEN_DEF,
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int SHIFT     = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mvm_done,
  input  logic signed [IN_WIDTH-1:0]  mvm_data_out,
  input  logic                        dst_ready,
  output logic                        load_vector,
  output logic signed [OUT_WIDTH-1:0] data_in,
  output logic                        sat_event,
  output logic                        overflow
);

  localparam int WC_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int RC_W = $clog2(VEC_LEN + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(VEC_LEN - 1);
  localparam logic [RC_W-1:0] RC_END  = RC_W'(VEC_LEN);

  cap_state_t  cap_state;
  drn_state_t  drn_state;
  logic [WC_W-1:0] wc;
  logic [RC_W-1:0] rc;
  logic        skip;
  logic        wptr;
  logic        rptr;
  logic [1:0]  full;
  logic [1:0]  full_next;
  logic        capt_done;
  logic        drain_release;
  logic        bank_free;

  logic signed [OUT_WIDTH-1:0] mem [2][VEC_LEN];
  logic signed [OUT_WIDTH-1:0] conv_word;
  logic                        conv_sat;

  mvm_relay_sat #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_sat (
    .word     (mvm_data_out),
    .narrowed (conv_word),
    .saturated(conv_sat)
  );

  assign capt_done     = (cap_state == C_CAPT) && (wc == WC_LAST);
  assign drain_release = (drn_state == D_SEND) && (rc == RC_END);
  // A bank released by the drain on this edge may be reused by a capture starting on it.
  assign bank_free     = !full[wptr] || (drain_release && (rptr == wptr));

  // Bank occupancy: capture sets, drain clears, both may act on the same edge.
  always_comb begin
    full_next = full;
    if (capt_done) begin
      full_next[wptr] = 1'b1;
    end else begin
      full_next[wptr] = full[wptr];
    end
    if (drain_release) begin
      full_next[rptr] = 1'b0;
    end else begin
      full_next[rptr] = full_next[rptr];
    end
  end

  // Bank full flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 2'b00;
    end else begin
      full <= full_next;
    end
  end

  // Capture FSM, overflow skip counting and saturation pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_state <= C_IDLE;
      wc        <= {WC_W{1'b0}};
      skip      <= 1'b0;
      wptr      <= 1'b0;
      overflow  <= 1'b0;
      sat_event <= 1'b0;
    end else begin
      sat_event <= (cap_state == C_CAPT) && conv_sat;
      case (cap_state)
        C_IDLE: begin
          if (skip) begin
            if (wc == WC_LAST) begin
              skip <= 1'b0;
              wc   <= {WC_W{1'b0}};
            end else begin
              wc <= wc + WC_W'(1);
            end
          end else if (mvm_done) begin
            wc <= {WC_W{1'b0}};
            if (bank_free) begin
              cap_state <= C_CAPT;
            end else begin
              overflow <= 1'b1;
              skip     <= 1'b1;
            end
          end else begin
            wc <= {WC_W{1'b0}};
          end
        end
        C_CAPT: begin
          if (wc == WC_LAST) begin
            cap_state <= C_IDLE;
            wptr      <= next_bank(wptr);
            wc        <= {WC_W{1'b0}};
          end else begin
            wc <= wc + WC_W'(1);
          end
        end
        default: begin
          cap_state <= C_IDLE;
          wc        <= {WC_W{1'b0}};
          skip      <= 1'b0;
        end
      endcase
    end
  end

  // Bank storage; contents are only meaningful while the matching full flag is set.
  always_ff @(posedge clk) begin
    if (cap_state == C_CAPT) begin
      mem[wptr][wc] <= conv_word;
    end
  end

  // Drain FSM: one load strobe, then VEC_LEN words back to back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drn_state   <= D_IDLE;
      rc          <= {RC_W{1'b0}};
      rptr        <= 1'b0;
      load_vector <= 1'b0;
      data_in     <= {OUT_WIDTH{1'b0}};
    end else begin
      case (drn_state)
        D_IDLE: begin
          data_in <= {OUT_WIDTH{1'b0}};
          rc      <= {RC_W{1'b0}};
          if (full[rptr] && dst_ready) begin
            drn_state   <= D_LOAD;
            load_vector <= 1'b1;
          end else begin
            load_vector <= 1'b0;
          end
        end
        D_LOAD: begin
          load_vector <= 1'b0;
          data_in     <= mem[rptr][{WC_W{1'b0}}];
          rc          <= RC_W'(1);
          drn_state   <= D_SEND;
        end
        D_SEND: begin
          load_vector <= 1'b0;
          if (rc == RC_END) begin
            data_in   <= {OUT_WIDTH{1'b0}};
            rptr      <= next_bank(rptr);
            rc        <= {RC_W{1'b0}};
            drn_state <= D_IDLE;
          end else begin
            data_in <= mem[rptr][rc[WC_W-1:0]];
            rc      <= rc + RC_W'(1);
          end
        end
        default: begin
          drn_state   <= D_IDLE;
          load_vector <= 1'b0;
          data_in     <= {OUT_WIDTH{1'b0}};
          rc          <= {RC_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_vec_relay.sv
// Self-checking bench for mvm_vec_relay: vector-queue model plus per-cycle output compare.
module tb_mvm_vec_relay;

  localparam int VL    = 12;
  localparam int SHIFT = 0;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               mvm_done = 1'b0;
  logic signed [31:0] mvm_data_out = 32'sd0;
  logic               dst_ready = 1'b1;
  logic               load_vector;
  logic signed [15:0] data_in;
  logic               sat_event;
  logic               overflow;

  mvm_vec_relay #(.VEC_LEN(VL), .IN_WIDTH(32), .OUT_WIDTH(16), .SHIFT(SHIFT)) dut (
    .clk         (clk),
    .reset       (reset),
    .mvm_done    (mvm_done),
    .mvm_data_out(mvm_data_out),
    .dst_ready   (dst_ready),
    .load_vector (load_vector),
    .data_in     (data_in),
    .sat_event   (sat_event),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model state
  int  exp_q[$];
  bit  chk_en   = 1'b0;
  bit  in_burst = 1'b0;
  int  pos      = 0;
  bit  cur_sat  = 1'b0;
  bit  sat_hold = 1'b0;
  bit  cur_drop = 1'b0;
  bit  ovf_exp  = 1'b0;
  int  sat_cnt  = 0;
  int  load_cyc = 0;
  int  done_edge = 0;
  int  last_burst[VL];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint clamp_ref(input int w);
    longint v;
    v = longint'(w) >>> SHIFT;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic bit sat_ref(input int w);
    longint v;
    v = longint'(w) >>> SHIFT;
    return (v > 32767) || (v < -32768);
  endfunction

  function automatic int conv_ref(input int w);
    longint v;
    v = clamp_ref(w);
`ifdef MVM_RELAY_RELU_EN
    if (v < 0) v = 0;
`endif
    return int'(v);
  endfunction

  // Per-cycle compare against the vector queue model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sat_event", sat_event, sat_hold);
      sat_hold = cur_sat;
      if (sat_event) sat_cnt++;
      chk("overflow", overflow, ovf_exp);
      if (cur_drop && mvm_done) ovf_exp = 1'b1;
      if (in_burst) begin
        chk("load_during_burst", load_vector, 0);
        if (exp_q.size() == 0) begin
          chk("burst_word_unexpected", data_in, 0);
          in_burst = 1'b0;
        end else begin
          chk("data_in_word", data_in, exp_q.pop_front());
          last_burst[pos] = data_in;
          pos++;
          if (pos == VL) in_burst = 1'b0;
        end
      end else begin
        chk("data_in_idle", data_in, 0);
        if (load_vector) begin
          chk("spurious_load", exp_q.size() >= VL, 1);
          if (exp_q.size() >= VL) begin
            in_burst = 1'b1;
            pos      = 0;
            load_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic send_vec(input int w[VL], input bit drop);
    if (!drop) for (int k = 0; k < VL; k++) exp_q.push_back(conv_ref(w[k]));
    @(posedge clk); #1;
    mvm_done = 1'b1; cur_drop = drop; done_edge = cyc + 1;
    @(posedge clk); #1;
    mvm_done = 1'b0; cur_drop = 1'b0;
    for (int k = 0; k < VL; k++) begin
      mvm_data_out = w[k];
      cur_sat = !drop && sat_ref(w[k]);
      @(posedge clk); #1;
    end
    mvm_data_out = 32'sd0;
    cur_sat = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || in_burst) && n < 300) begin
      @(negedge clk); #2;
      n++;
    end
    chk({name, "_drain_timeout"}, n < 300, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    in_burst = 1'b0; pos = 0;
    sat_hold = 1'b0; cur_sat = 1'b0; cur_drop = 1'b0; ovf_exp = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[VL];
    int s0;
    int n;

    // reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_load", load_vector, 0);
    chk("rst_data", data_in, 0);
    chk("rst_sat", sat_event, 0);
    chk("rst_ovf", overflow, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // single vector, latency
    for (int k = 0; k < VL; k++) v[k] = k;
    send_vec(v, 1'b0);
    wait_drained("single");
    chk("latency_load", load_cyc - done_edge, 13);
    chk("single_w0", last_burst[0], 0);
    chk("single_w5", last_burst[5], 5);
    chk("single_w11", last_burst[11], 11);

    // saturation
    s0 = sat_cnt;
    v = '{40000, -40000, 123, -1, 32767, -32768, 0, 1, 2, 3, 4, 5};
    send_vec(v, 1'b0);
    wait_drained("sat");
    chk("sat_hi", last_burst[0], 32767);
    chk("sat_lo", last_burst[1], -32768);
    chk("sat_pass", last_burst[2], 123);
    chk("sat_edge_max", last_burst[4], 32767);
    chk("sat_pulses", sat_cnt - s0, 2);

    // buffering and overflow
    dst_ready = 1'b0;
    for (int k = 0; k < VL; k++) v[k] = 200 + k;
    send_vec(v, 1'b0);
    for (int k = 0; k < VL; k++) v[k] = 300 + k;
    send_vec(v, 1'b0);
    for (int k = 0; k < VL; k++) v[k] = 999;
    send_vec(v, 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("ovf_set", overflow, 1);
    chk("no_drain_while_not_ready", load_vector, 0);
    dst_ready = 1'b1;
    wait_drained("buffer");
    chk("buffer_v2_w0", last_burst[0], 300);
    chk("buffer_v2_w11", last_burst[11], 311);
    repeat (30) @(posedge clk);
    #1 chk("ovf_sticky", overflow, 1);

    // reset mid-drain after word 5
    for (int k = 0; k < VL; k++) v[k] = 100 + k;
    send_vec(v, 1'b0);
    n = 0;
    while (!(in_burst && pos >= 6) && n < 300) begin
      @(negedge clk); #2;
      n++;
    end
    chk("middrain_reach", n < 300, 1);
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("middrain_load", load_vector, 0);
    chk("middrain_data", data_in, 0);
    chk("middrain_sat", sat_event, 0);
    chk("middrain_ovf", overflow, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (30) @(posedge clk);
    for (int k = 0; k < VL; k++) v[k] = 50 - 3 * k;
    send_vec(v, 1'b0);
    wait_drained("fresh");
    chk("fresh_w0", last_burst[0], 50);
    chk("fresh_w11", last_burst[11], 17);

    // ReLU option
    v = '{-5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
    send_vec(v, 1'b0);
    wait_drained("relu");
`ifdef MVM_RELAY_RELU_EN
    chk("relu_neg", last_burst[0], 0);
    chk("relu_neg1", last_burst[11], 0);
`else
    chk("relu_neg", last_burst[0], -5);
    chk("relu_neg1", last_burst[11], -1);
`endif
    chk("relu_pos", last_burst[1], 7);

    chk("queue_empty", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
